// File: rtl/ijtag_access_ctrl_if.sv
// Host command/response port of the IJTAG access controller.
// master = host side, slave = controller side.
interface ijtag_access_ctrl_if #(
  parameter int MAX_LEN = 64
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               cmd_valid;
  logic               cmd_ready;
  logic [LEN_W-1:0]   cmd_len;
  logic               cmd_capture;
  logic               cmd_update;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [MAX_LEN-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_len, cmd_capture, cmd_update, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_len, cmd_capture, cmd_update, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/ijtag_access_ctrl.sv
// IJTAG scan-network initiator: runs capture / N shifts / update per host command.
// Optional network-reset phase enabled by defining IJTAG_CTRL_NET_RESET_EN.
module ijtag_access_ctrl #(
  parameter int MAX_LEN = 64
) (
  input  logic               ijtag_tck,
  input  logic               ijtag_reset,
  ijtag_access_ctrl_if.slave cmd_if,
  output logic               ijtag_sel,
  output logic               ijtag_ce,
  output logic               ijtag_se,
  output logic               ijtag_ue,
  output logic               ijtag_si,
  input  logic               ijtag_so
`ifdef IJTAG_CTRL_NET_RESET_EN
  ,
  input  logic               cmd_net_reset,
  output logic               ijtag_net_reset
`endif
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_NRST  = 3'd1;
  localparam logic [2:0] S_CAP   = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_UPD   = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               cap_q, cap_d;
  logic               upd_q, upd_d;
  logic [MAX_LEN-1:0] sdata_q, sdata_d;
  logic [MAX_LEN-1:0] rsp_q, rsp_d;
  logic               sel_q, sel_d;
  logic               ce_q, ce_d;
  logic               se_q, se_d;
  logic               ue_q, ue_d;
  logic               si_q, si_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [LEN_W-1:0]   len_clamped;

`ifdef IJTAG_CTRL_NET_RESET_EN
  logic [1:0]         nrst_cnt_q, nrst_cnt_d;
  logic               nrst_act_q, nrst_act_d;
`endif

  // Next work phase after 'from', skipping phases that have nothing to do.
  function automatic logic [2:0] stage_after(input logic [2:0] from, input logic cap,
                                             input logic len_nz, input logic upd);
    if ((from == S_IDLE || from == S_NRST) && cap) return S_CAP;
    if (from != S_SHIFT && len_nz) return S_SHIFT;
    if (upd) return S_UPD;
    return S_RESP;
  endfunction

  assign len_clamped = (cmd_if.cmd_len > LEN_MAX) ? LEN_MAX : cmd_if.cmd_len;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    upd_d   = upd_q;
    sdata_d = sdata_q;
    rsp_d   = rsp_q;
`ifdef IJTAG_CTRL_NET_RESET_EN
    nrst_cnt_d = nrst_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_if.cmd_valid) begin
          len_d   = len_clamped;
          cnt_d   = '0;
          cap_d   = cmd_if.cmd_capture;
          upd_d   = cmd_if.cmd_update;
          sdata_d = cmd_if.cmd_data;
          rsp_d   = '0;
          state_d = stage_after(S_IDLE, cmd_if.cmd_capture, len_clamped != '0, cmd_if.cmd_update);
`ifdef IJTAG_CTRL_NET_RESET_EN
          nrst_cnt_d = '0;
          if (cmd_net_reset) state_d = S_NRST;
`endif
        end
      end
`ifdef IJTAG_CTRL_NET_RESET_EN
      S_NRST: begin
        nrst_cnt_d = nrst_cnt_q + 2'd1;
        if (nrst_cnt_q == 2'd3) state_d = stage_after(S_NRST, cap_q, len_q != '0, upd_q);
      end
`endif
      S_CAP: state_d = stage_after(S_CAP, cap_q, len_q != '0, upd_q);
      S_SHIFT: begin
        // so is sampled at the posedge closing shift cnt_q; the next si bit moves to sdata[0].
        rsp_d[cnt_q[IDX_W-1:0]] = ijtag_so;
        sdata_d = sdata_q >> 1;
        cnt_d   = cnt_q + LEN_W'(1);
        if (cnt_d == len_q) state_d = stage_after(S_SHIFT, cap_q, 1'b1, upd_q);
      end
      S_UPD:  state_d = S_RESP;
      S_RESP: if (cmd_if.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Bus outputs are registered copies of what the next state presents.
    sel_d       = (state_d == S_CAP) || (state_d == S_SHIFT) || (state_d == S_UPD);
    ce_d        = (state_d == S_CAP);
    se_d        = (state_d == S_SHIFT);
    ue_d        = (state_d == S_UPD);
    si_d        = (state_d == S_SHIFT) && sdata_d[0];
    cmd_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
`ifdef IJTAG_CTRL_NET_RESET_EN
    nrst_act_d  = (state_d == S_NRST);
`endif
  end

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      cap_q       <= 1'b0;
      upd_q       <= 1'b0;
      sdata_q     <= '0;
      rsp_q       <= '0;
      sel_q       <= 1'b0;
      ce_q        <= 1'b0;
      se_q        <= 1'b0;
      ue_q        <= 1'b0;
      si_q        <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
`ifdef IJTAG_CTRL_NET_RESET_EN
      nrst_cnt_q  <= '0;
      nrst_act_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
      upd_q       <= upd_d;
      sdata_q     <= sdata_d;
      rsp_q       <= rsp_d;
      sel_q       <= sel_d;
      ce_q        <= ce_d;
      se_q        <= se_d;
      ue_q        <= ue_d;
      si_q        <= si_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef IJTAG_CTRL_NET_RESET_EN
      nrst_cnt_q  <= nrst_cnt_d;
      nrst_act_q  <= nrst_act_d;
`endif
    end
  end

  assign cmd_if.cmd_ready = cmd_ready_q;
  assign cmd_if.rsp_valid = rsp_valid_q;
  assign cmd_if.rsp_data  = rsp_q;
  assign ijtag_sel        = sel_q;
  assign ijtag_ce         = ce_q;
  assign ijtag_se         = se_q;
  assign ijtag_ue         = ue_q;
  assign ijtag_si         = si_q;
`ifdef IJTAG_CTRL_NET_RESET_EN
  // Gated with the async reset so the network is held in reset while the controller is.
  assign ijtag_net_reset  = ijtag_reset & ~nrst_act_q;
`endif
endmodule
